// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding, register offsets, modes and CTRL bit positions for the timer.
package timer_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    localparam int EN      = 0;
    localparam int MODE_LO = 1;
    localparam int MODE_HI = 2;
    localparam int IM      = 3;

endpackage

// File: rtl/timer.sv
// timer: memory-mapped countdown timer with one-shot (level irq) and auto-reload (pulse irq) modes.
module timer
    import timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        irq
);

    state_t             state, state_n;
    logic [3:0]         ctrl;
    logic [CNT_W-1:0]   preset, count, count_n;
    logic               flag, flag_n, set_flag, en_clr;
    logic               wr_ctrl, wr_preset;

    assign wr_ctrl   = we && addr == REG_CTRL;
    assign wr_preset = we && addr == REG_PRESET;

    always_comb begin
        state_n  = state;
        count_n  = count;
        set_flag = 1'b0;
        en_clr   = 1'b0;
        flag_n   = flag;
        case (state)
            IDLE: state_n = ctrl[EN] ? LOAD : IDLE;
            LOAD: begin
                count_n = preset;
                state_n = CNT;
            end
            CNT: begin
                if (!ctrl[EN])
                    state_n = IDLE;
                else if (count > CNT_W'(1))
                    count_n = count - CNT_W'(1);
                else begin
                    count_n  = '0;
                    set_flag = 1'b1;
                    state_n  = INT;
                end
            end
            INT: begin
                state_n = IDLE;
                if (ctrl[MODE_HI:MODE_LO] == MODE_RELOAD)
                    flag_n = 1'b0;
                else
                    en_clr = 1'b1;
            end
            default: state_n = IDLE;
        endcase
        // a flag set in this cycle outranks the clear caused by a config write
        flag_n = set_flag ? 1'b1 : (wr_ctrl || wr_preset) ? 1'b0 : flag_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            ctrl   <= '0;
            preset <= '0;
            count  <= '0;
            flag   <= 1'b0;
        end else begin
            state <= state_n;
            count <= count_n;
            flag  <= flag_n;
            if (wr_ctrl)
                ctrl <= wd[3:0];
            else if (en_clr)
                ctrl[EN] <= 1'b0;
            if (wr_preset)
                preset <= wd[CNT_W-1:0];
        end
    end

    assign rd  = addr == REG_CTRL   ? {28'd0, ctrl} :
                 addr == REG_PRESET ? 32'(preset)   :
                 addr == REG_COUNT  ? 32'(count)    : 32'd0;
    assign irq = flag & ctrl[IM];

endmodule

// File: tb/tb_timer.sv
// tb_timer: directed stimulus pushes expected read/irq values; a negedge monitor pops and compares.
module tb_timer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  addr = 2'd0;
    logic        we = 1'b0;
    logic [31:0] wd = 32'd0;
    logic [31:0] rd;
    logic        irq;
    logic        sample = 1'b0;

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic        irq;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    timer #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .addr(addr), .we(we), .wd(wd), .rd(rd), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    always @(negedge clk) begin
        if (sample) begin
            if (q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty got rd=%h irq=%b", rd, irq);
            end else begin
                exp_t e;
                e = q.pop_front();
                checks++;
                if (rd !== e.rd || irq !== e.irq) begin
                    errors++;
                    $display("FAIL %s got rd=%h irq=%b expected rd=%h irq=%b", e.name, rd, irq, e.rd, e.irq);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr = a;
        wd   = d;
        we   = 1'b1;
        tick();
        we   = 1'b0;
    endtask

    // observes the state left by the most recent edge; back-to-back calls step one edge each
    task automatic chk(input string name, input logic [1:0] a, input logic [31:0] v, input logic i);
        exp_t e;
        e.name = name;
        e.rd   = v;
        e.irq  = i;
        q.push_back(e);
        addr   = a;
        sample = 1'b1;
        @(negedge clk);
        #1;
        sample = 1'b0;
    endtask

    initial begin
        int cnt_os[8]   = '{0, 0, 5, 4, 3, 2, 1, 0};
        int cnt_mask[6] = '{3, 3, 2, 1, 0, 0};
        int cnt_dis[6]  = '{0, 0, 10, 9, 8, 7};
        int cnt_mid[6]  = '{2, 1, 0, 0, 0, 7};
        int irq_mid[6]  = '{0, 0, 1, 0, 0, 0};

        tick(2);
        reset = 1'b0;
        chk("rst_ctrl", 2'd0, 32'd0, 1'b0);
        chk("rst_preset", 2'd1, 32'd0, 1'b0);
        chk("rst_count", 2'd2, 32'd0, 1'b0);
        chk("rst_rsvd", 2'd3, 32'd0, 1'b0);
        wr(2'd2, 32'h1234);
        chk("count_wr_ignored", 2'd2, 32'd0, 1'b0);

        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        for (int k = 0; k < 8; k++)
            chk("os_count", 2'd2, 32'(cnt_os[k]), k == 7);
        chk("os_en_clear", 2'd0, 32'h8, 1'b1);
        chk("os_irq_held", 2'd2, 32'd0, 1'b1);
        wr(2'd0, 32'h8);
        chk("os_irq_ack", 2'd0, 32'h8, 1'b0);

        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        for (int k = 0; k < 25; k++)
            chk("ar_pulse", 2'd0, 32'hB, k >= 5 && (k - 5) % 6 == 0);
        wr(2'd0, 32'h8);
        tick(3);

        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        for (int k = 0; k < 6; k++)
            chk("mask_count", 2'd2, 32'(cnt_mask[k]), 1'b0);
        chk("mask_en_clear", 2'd0, 32'd0, 1'b0);
        wr(2'd0, 32'h8);
        chk("mask_flag_cleared", 2'd0, 32'h8, 1'b0);

        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);
        for (int k = 0; k < 6; k++)
            chk("dis_count", 2'd2, 32'(cnt_dis[k]), 1'b0);
        wr(2'd0, 32'h8);
        chk("dis_hold0", 2'd2, 32'd6, 1'b0);
        chk("dis_hold1", 2'd2, 32'd6, 1'b0);
        chk("dis_hold2", 2'd2, 32'd6, 1'b0);
        wr(2'd0, 32'h9);
        chk("reen_idle", 2'd2, 32'd6, 1'b0);
        chk("reen_load", 2'd2, 32'd6, 1'b0);
        chk("reen_reload", 2'd2, 32'd10, 1'b0);
        wr(2'd0, 32'h8);
        tick(3);

        wr(2'd1, 32'd4);
        wr(2'd0, 32'hB);
        chk("mid_count", 2'd2, 32'd9, 1'b0);
        chk("mid_count", 2'd2, 32'd9, 1'b0);
        chk("mid_count", 2'd2, 32'd4, 1'b0);
        chk("mid_count", 2'd2, 32'd3, 1'b0);
        wr(2'd1, 32'd7);
        for (int k = 0; k < 6; k++)
            chk("mid_preset", 2'd2, 32'(cnt_mid[k]), irq_mid[k] != 0);
        chk("mid_next", 2'd2, 32'd6, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_count", 2'd2, 32'd0, 1'b0);
        chk("midrst_ctrl", 2'd0, 32'd0, 1'b0);
        chk("midrst_preset", 2'd1, 32'd0, 1'b0);

        wr(2'd1, 32'd2);
        wr(2'd0, 32'h9);
        tick(3);
        wr(2'd0, 32'h9);
        chk("set_beats_wr", 2'd0, 32'h9, 1'b1);
        wr(2'd0, 32'h9);
        chk("wr_beats_enclr", 2'd0, 32'h9, 1'b0);
        wr(2'd0, 32'h0);
        tick(2);

        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
